if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register. Holds the PC and issues
//  instruction-memory requests with a one-outstanding handshake. Latches each
//  fetched word into IF/ID. id_imm feeds the immediate extender in decode
//  directly; id_instr feeds the decoder. Honours stall from the hazard unit and
//  redirect (branch/jump flush) from decode/execute.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC value loaded on reset; first fetch address
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   async reset, active-high
//  imem_req     out  1   fetch request valid
//  imem_addr    out  32  fetch address, word aligned ([1:0]=00)
//  imem_ready   in   1   memory accepts request this cycle (req&ready = accepted)
//  imem_rvalid  in   1   response data valid
//  imem_rdata   in   32  instruction word
//  stall        in   1   decode cannot accept a new instruction; IF/ID holds
//  redirect     in   1   flush pipe and restart fetch at redirect_pc
//  redirect_pc  in   32  new PC; bits [1:0] ignored, forced 00
//  id_valid     out  1   IF/ID holds a real instruction (0 = bubble)
//  id_instr     out  32  IF/ID instruction word
//  id_pc        out  32  PC of id_instr
//  id_pc_plus4  out  32  id_pc+4 (comb, mod 2^32)
//  id_imm       out  16  id_instr[15:0] (comb), to immediate extender
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=REQ, squash=0, id_valid=0, id_instr=0,
//   id_pc=0, hold buffer=0. After release, imem_req=1, imem_addr=RESET_PC.
//  FSM states REQ, WAIT, HOLD:
//   REQ : imem_req=~redirect, imem_addr=pc. On req&ready: pend_pc<=pc -> WAIT.
//         Any rvalid seen in REQ is ignored.
//   WAIT: imem_req=0. On rvalid:
//         - if squash or redirect: drop data, squash<=0 -> REQ.
//         - else if ~stall: IF/ID<=(1,rdata,pend_pc), pc<=pend_pc+4 -> REQ.
//         - else: hold buffer<=(rdata,pend_pc) -> HOLD.
//         redirect without rvalid: squash<=1, stay WAIT.
//   HOLD: imem_req=0. When ~stall: IF/ID<=buffer, pc<=buf_pc+4 -> REQ.
//  IF/ID update, priority high->low:
//   1. redirect: id_valid<=0 (flush), pc<=redirect_pc&~3. HOLD -> REQ, buffer
//      dropped. WAIT sets squash as above.
//   2. stall: id_* unchanged.
//   3. no new instruction this edge: id_valid<=0 (bubble); other id_* unchanged.
//  Redirect beats stall; redirect beats a simultaneous rvalid.
//  Latency: accepted request + rvalid next cycle -> id_valid on the edge after
//   rvalid. Peak rate 1 instr per 2 cycles. Never more than 1 request outstanding.
//  PC arithmetic is 32-bit and wraps: 0xFFFFFFFC+4 = 0x00000000.
//  Reset mid-WAIT: the outstanding response is not tracked. A late rvalid lands
//   in REQ and is ignored.
// TESTING
//  1. Reset release, imem_ready=0 -> imem_req=1, imem_addr=0x3000, id_valid=0;
//     holds until ready.
//  2. ready=1; rvalid next cycle, rdata=0x2408FFFF -> next edge id_valid=1,
//     id_instr=0x2408FFFF, id_imm=0xFFFF, id_pc=0x3000, id_pc_plus4=0x3004;
//     then imem_addr=0x3004.
//  3. stall=1 while rvalid (rdata=0x3C011234) -> id_* unchanged, imem_req=0 for
//     3 cycles. Drop stall -> id_instr=0x3C011234, id_imm=0x1234, next addr +4.
//  4. redirect=1, redirect_pc=0x3101 in WAIT, rvalid 2 cycles later -> data
//     dropped, id_valid=0, next imem_addr=0x3100. Repeat with redirect+stall
//     together -> id_valid=0 (flush wins).
//  5. redirect_pc=0xFFFFFFFC, fetch completes -> id_pc=0xFFFFFFFC,
//     id_pc_plus4=0x0, next imem_addr=0x00000000.
//  6. Assert rst mid-WAIT, rvalid after release -> ignored, id_valid=0,
//     imem_addr=0x3000, no spurious IF/ID load.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus: one request/accept handshake plus a response
// channel. The fetch stage is the master and memory is the slave.
interface if_stage_if;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, output addr, input ready, input rvalid, input rdata);
   modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register. It keeps at most one fetch
// outstanding and honours stall and redirect from later stages.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic              clk,
   input  logic              rst,
   if_stage_if.master        imem,
   input  logic              stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic              id_valid,
   output logic [31:0]       id_instr,
   output logic [31:0]       id_pc,
   output logic [31:0]       id_pc_plus4,
   output logic [15:0]       id_imm
);

   typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

   state_t      state, state_nx;
   logic [31:0] pc, pc_nx;
   logic [31:0] pend_pc;
   logic [31:0] buf_instr, buf_pc;
   logic        squash;
   logic        take_pend, load_id, from_buf, load_buf, set_squash, clr_squash;
   logic [31:0] redirect_al;

   assign redirect_al = {redirect_pc[31:2], 2'b00};
   assign imem.addr   = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= REQ;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      pc_nx      = pc;
      imem.req   = 1'b0;
      take_pend  = 1'b0;
      load_id    = 1'b0;
      from_buf   = 1'b0;
      load_buf   = 1'b0;
      set_squash = 1'b0;
      clr_squash = 1'b0;
      case (state)
         REQ: begin
            imem.req = ~redirect;
            if (redirect) begin
               pc_nx = redirect_al;
            end else if (imem.ready) begin
               take_pend = 1'b1;
               state_nx  = WAIT;
            end
         end
         WAIT: begin
            if (imem.rvalid) begin
               if (squash || redirect) begin
                  clr_squash = 1'b1;
                  state_nx   = REQ;
               end else if (!stall) begin
                  load_id  = 1'b1;
                  pc_nx    = pend_pc + 32'd4;
                  state_nx = REQ;
               end else begin
                  load_buf = 1'b1;
                  state_nx = HOLD;
               end
            end else if (redirect) begin
               set_squash = 1'b1;
            end
            if (redirect) pc_nx = redirect_al;
         end
         HOLD: begin
            if (redirect) begin
               pc_nx    = redirect_al;
               state_nx = REQ;
            end else if (!stall) begin
               load_id  = 1'b1;
               from_buf = 1'b1;
               pc_nx    = buf_pc + 32'd4;
               state_nx = REQ;
            end
         end
         default: state_nx = REQ;
      endcase
   end

   // Fetch-side registers: PC, squash marker, hold buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc        <= RESET_PC;
         squash    <= 1'b0;
         buf_instr <= 32'd0;
         buf_pc    <= 32'd0;
      end else begin
         pc <= pc_nx;
         if (clr_squash)      squash <= 1'b0;
         else if (set_squash) squash <= 1'b1;
         if (load_buf) begin
            buf_instr <= imem.rdata;
            buf_pc    <= pend_pc;
         end
      end
   end

   // The in-flight address is not reset: a late response after reset is ignored.
   always_ff @(posedge clk) begin
      if (take_pend) pend_pc <= pc;
   end

   // IF/ID register: flush beats stall, stall beats bubble insertion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_valid <= 1'b0;
         id_instr <= 32'd0;
         id_pc    <= 32'd0;
      end else if (redirect) begin
         id_valid <= 1'b0;
      end else if (!stall) begin
         if (load_id) begin
            id_valid <= 1'b1;
            id_instr <= from_buf ? buf_instr : imem.rdata;
            id_pc    <= from_buf ? buf_pc    : pend_pc;
         end else begin
            id_valid <= 1'b0;
         end
      end
   end

   assign id_pc_plus4 = id_pc + 32'd4;
   assign id_imm      = id_instr[15:0];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a per-cycle vector table covering fetch, stall,
// redirect and PC wrap, then a hand-written reset-during-fetch sequence.
module tb_if_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        stall, redirect;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic [31:0] id_instr, id_pc, id_pc_plus4;
   logic [15:0] id_imm;
   int          checks = 0;
   int          failures = 0;

   if_stage_if imem_bus();

   if_stage #(.RESET_PC(32'h0000_3000)) dut (
      .clk(clk), .rst(rst), .imem(imem_bus), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .id_valid(id_valid), .id_instr(id_instr),
      .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_imm(id_imm)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st, rd;
      logic [31:0] rpc;
      logic        rdy, rv;
      logic [31:0] rdata;
      logic        ereq;
      logic [31:0] eaddr;
      logic        ev;
      logic [31:0] ei, ep;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_id(input string tag, input logic ev, input logic [31:0] ei,
                         input logic [31:0] ep);
      logic [31:0] eplus;
      logic [15:0] eimm;
      eplus = ep + 32'd4;
      eimm  = ei[15:0];
      chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, ev});
      chk({tag, ".id_instr"}, id_instr, ei);
      chk({tag, ".id_pc"}, id_pc, ep);
      chk({tag, ".id_pc_plus4"}, id_pc_plus4, eplus);
      chk({tag, ".id_imm"}, {16'd0, id_imm}, {16'd0, eimm});
   endtask

   task automatic add(input logic st, input logic rd, input logic [31:0] rpc,
                      input logic rdy, input logic rv, input logic [31:0] rdata,
                      input logic ereq, input logic [31:0] eaddr,
                      input logic ev, input logic [31:0] ei, input logic [31:0] ep);
      vec_t t;
      t.st = st; t.rd = rd; t.rpc = rpc; t.rdy = rdy; t.rv = rv; t.rdata = rdata;
      t.ereq = ereq; t.eaddr = eaddr; t.ev = ev; t.ei = ei; t.ep = ep;
      vecs.push_back(t);
   endtask

   task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic rdy, input logic rv, input logic [31:0] rdata);
      stall = st; redirect = rd; redirect_pc = rpc;
      imem_bus.ready = rdy; imem_bus.rvalid = rv; imem_bus.rdata = rdata;
   endtask

   initial begin
      // st rd rpc  rdy rv rdata | req addr | v instr pc
      add(0,0,0,          0,0,0,            1,32'h3000,     0,0,0);
      add(0,0,0,          0,0,0,            1,32'h3000,     0,0,0);
      add(0,0,0,          1,0,0,            1,32'h3000,     0,0,0);
      add(0,0,0,          0,1,32'h2408FFFF, 0,32'h3000,     1,32'h2408FFFF,32'h3000);
      add(0,0,0,          0,0,0,            1,32'h3004,     0,32'h2408FFFF,32'h3000);
      add(0,0,0,          1,0,0,            1,32'h3004,     0,32'h2408FFFF,32'h3000);
      add(1,0,0,          0,1,32'h3C011234, 0,32'h3004,     0,32'h2408FFFF,32'h3000);
      add(1,0,0,          0,0,0,            0,32'h3004,     0,32'h2408FFFF,32'h3000);
      add(1,0,0,          0,0,0,            0,32'h3004,     0,32'h2408FFFF,32'h3000);
      add(0,0,0,          0,0,0,            0,32'h3004,     1,32'h3C011234,32'h3004);
      add(1,0,0,          0,0,0,            1,32'h3008,     1,32'h3C011234,32'h3004);
      add(0,0,0,          1,0,0,            1,32'h3008,     0,32'h3C011234,32'h3004);
      add(0,1,32'h3101,   0,0,0,            0,32'h3008,     0,32'h3C011234,32'h3004);
      add(0,0,0,          0,0,0,            0,32'h3100,     0,32'h3C011234,32'h3004);
      add(0,0,0,          0,1,32'hDEADBEEF, 0,32'h3100,     0,32'h3C011234,32'h3004);
      add(0,0,0,          0,0,0,            1,32'h3100,     0,32'h3C011234,32'h3004);
      add(0,0,0,          1,0,0,            1,32'h3100,     0,32'h3C011234,32'h3004);
      add(0,0,0,          0,1,32'h00000001, 0,32'h3100,     1,32'h00000001,32'h3100);
      add(1,1,32'h3200,   0,0,0,            0,32'h3104,     0,32'h00000001,32'h3100);
      add(0,0,0,          1,0,0,            1,32'h3200,     0,32'h00000001,32'h3100);
      add(1,1,32'h3300,   0,1,32'h11111111, 0,32'h3200,     0,32'h00000001,32'h3100);
      add(0,0,0,          0,0,0,            1,32'h3300,     0,32'h00000001,32'h3100);
      add(0,1,32'hFFFFFFFE,0,0,0,           0,32'h3300,     0,32'h00000001,32'h3100);
      add(0,0,0,          1,0,0,            1,32'hFFFFFFFC, 0,32'h00000001,32'h3100);
      add(0,0,0,          0,1,32'h8C000004, 0,32'hFFFFFFFC, 1,32'h8C000004,32'hFFFFFFFC);
      add(0,0,0,          0,0,0,            1,32'h00000000, 0,32'h8C000004,32'hFFFFFFFC);
      add(0,0,0,          1,0,0,            1,32'h00000000, 0,32'h8C000004,32'hFFFFFFFC);
      add(1,0,0,          0,1,32'h22222222, 0,32'h00000000, 0,32'h8C000004,32'hFFFFFFFC);
      add(1,1,32'h4000,   0,0,0,            0,32'h00000000, 0,32'h8C000004,32'hFFFFFFFC);
      add(0,0,0,          0,1,32'h33333333, 1,32'h4000,     0,32'h8C000004,32'hFFFFFFFC);

      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk("reset.req", {31'd0, imem_bus.req}, 32'd1);
      chk("reset.addr", imem_bus.addr, 32'h3000);
      chk_id("reset", 1'b0, 32'd0, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         drive(vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].rdy, vecs[i].rv, vecs[i].rdata);
         #1;
         chk({tag, ".req"}, {31'd0, imem_bus.req}, {31'd0, vecs[i].ereq});
         chk({tag, ".addr"}, imem_bus.addr, vecs[i].eaddr);
         @(posedge clk); #1;
         chk_id(tag, vecs[i].ev, vecs[i].ei, vecs[i].ep);
      end

      // Reset while a fetch is outstanding; the late response must be ignored
      drive(0, 0, 0, 1, 0, 0);
      @(posedge clk); #1;
      chk("rstwait.req", {31'd0, imem_bus.req}, 32'd0);
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #1;
      chk("rstwait.addr_in_reset", imem_bus.addr, 32'h3000);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(0, 0, 0, 0, 1, 32'h55555555);
      #1;
      chk("rstwait.req_after", {31'd0, imem_bus.req}, 32'd1);
      chk("rstwait.addr_after", imem_bus.addr, 32'h3000);
      @(posedge clk); #1;
      chk_id("rstwait.late", 1'b0, 32'd0, 32'd0);
      drive(0, 0, 0, 1, 0, 0);
      #1;
      chk("rstwait.refetch_addr", imem_bus.addr, 32'h3000);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 1, 32'h66667777);
      @(posedge clk); #1;
      chk_id("rstwait.refetch", 1'b1, 32'h66667777, 32'h3000);
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk("rstwait.next_addr", imem_bus.addr, 32'h3004);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
